// File: rtl/seg7_mux.sv
// rtl/seg7_mux.sv - multiplexed 7-segment display controller with bus registers
//
// Scans DIGITS digits one at a time. Each digit is shown for 2^CNT_BITS clocks.
// PWM brightness gates the anode inside each digit period.
// Four word registers sit at BASE..BASE+3:
//   HEX (nibble per digit), DP, BLANK, CTRL (duty).
//
// Build option: define SEG7_READ_EN to enable register readback.
//   Without it, rdata is tied to 0, and read hits are still acknowledged.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   strobe bus cycle valid
//   rw     1 = write, 0 = read
//   addr   word address
//   data   write data
//   rdata  registered read data
//   ack    one-cycle pulse after any hit
//   seg    active-low segments, [6:0] = g..a, [7] = decimal point
//   an     active-low anode enables, at most one low
module seg7_mux #(
  parameter logic [31:0] BASE        = 32'h10,
  parameter int          DIGITS      = 4,
  parameter int          CNT_BITS    = 16,
  parameter int          BRIGHT_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              strobe,
  input  logic              rw,
  input  logic [31:0]       addr,
  input  logic [31:0]       data,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_BITS-1:0]    counter_q, counter_d;
  logic [DW-1:0]          dig_q, dig_d;
  logic [4*DIGITS-1:0]    hex_q, hex_d;
  logic [DIGITS-1:0]      dp_q, dp_d;
  logic [DIGITS-1:0]      blank_q, blank_d;
  logic [BRIGHT_BITS-1:0] duty_q, duty_d;
  logic                   ack_q;
  logic [DIGITS-1:0]      an_q, an_d;
  logic [7:0]             seg_q, seg_d;

  logic                   hit;
  logic [BRIGHT_BITS-1:0] phase;
  logic                   lit;
  logic [3:0]             cur_nib;
  logic                   cur_dp;
  logic                   cur_blank;
  logic                   show;

  // Data bits above the widest register are intentionally ignored.
  logic unused_data;
  assign unused_data = ^data;

  assign hit = strobe && (addr[31:2] == BASE[31:2]);

  // Active-low glyphs, bit order g..a.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  // Register writes. These are independent of the scan, so they are never blocked.
  always_comb begin
    hex_d   = hex_q;
    dp_d    = dp_q;
    blank_d = blank_q;
    duty_d  = duty_q;
    if (hit && rw) begin
      case (addr[1:0])
        2'd0:    hex_d   = data[4*DIGITS-1:0];
        2'd1:    dp_d    = data[DIGITS-1:0];
        2'd2:    blank_d = data[DIGITS-1:0];
        default: duty_d  = data[BRIGHT_BITS-1:0];
      endcase
    end
  end

  // Scan counter, plus a digit index that wraps at DIGITS-1
  // (so DIGITS need not be a power of two).
  always_comb begin
    counter_d = counter_q + 1'b1;
    dig_d     = dig_q;
    if (&counter_q) begin
      dig_d = (dig_q == DW'(DIGITS - 1)) ? '0 : dig_q + 1'b1;
    end
  end

  // PWM: the top bits of the counter give the phase within the digit period.
  // An all-ones duty forces full on.
  // Otherwise the digit is lit while phase < duty.
  assign phase = counter_q[CNT_BITS-1 -: BRIGHT_BITS];
  assign lit   = (&duty_q) || (phase < duty_q);

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q == DW'(i)) begin
        cur_nib   = hex_q[4*i +: 4];
        cur_dp    = dp_q[i];
        cur_blank = blank_q[i];
      end
    end
  end

  // A blanked digit darkens the anode and the segments together,
  // so seg is all-ones whenever an is.
  assign show = lit && !cur_blank;

  always_comb begin
    an_d  = '1;
    seg_d = 8'hFF;
    if (show) begin
      for (int i = 0; i < DIGITS; i++) begin
        an_d[i] = !(dig_q == DW'(i));
      end
      seg_d = {~cur_dp, hex_glyph(cur_nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= '0;
      dig_q     <= '0;
      hex_q     <= '0;
      dp_q      <= '0;
      blank_q   <= '0;
      duty_q    <= '1;
      ack_q     <= 1'b0;
      an_q      <= '1;
      seg_q     <= 8'hFF;
    end else begin
      counter_q <= counter_d;
      dig_q     <= dig_d;
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      blank_q   <= blank_d;
      duty_q    <= duty_d;
      ack_q     <= hit;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign ack = ack_q;
  assign an  = an_q;
  assign seg = seg_q;

`ifdef SEG7_READ_EN
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_sel;

  // Readback samples the registers before this edge's update.
  // Since a read and a write cannot coincide, a read after a write sees the new value.
  always_comb begin
    rd_sel = '0;
    case (addr[1:0])
      2'd0:    rd_sel[4*DIGITS-1:0]    = hex_q;
      2'd1:    rd_sel[DIGITS-1:0]      = dp_q;
      2'd2:    rd_sel[DIGITS-1:0]      = blank_q;
      default: rd_sel[BRIGHT_BITS-1:0] = duty_q;
    endcase
    rdata_d = rdata_q;
    if (hit && !rw) begin
      rdata_d = rd_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
`else
  assign rdata = '0;
`endif

endmodule

// File: tb/tb_seg7_mux.sv
// tb/tb_seg7_mux.sv - self-checking bench for seg7_mux (4-digit and 5-digit builds)
module tb_seg7_mux;

`ifdef SEG7_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        strobe = 1'b0;
  logic        rw = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] data = '0;

  logic [31:0] rdata4, rdata5;
  logic        ack4, ack5;
  logic [7:0]  seg4, seg5;
  logic [3:0]  an4;
  logic [4:0]  an5;

  seg7_mux #(.BASE(32'h10), .DIGITS(4), .CNT_BITS(4), .BRIGHT_BITS(4)) u4 (
    .clk(clk), .reset(reset), .strobe(strobe), .rw(rw), .addr(addr), .data(data),
    .rdata(rdata4), .ack(ack4), .seg(seg4), .an(an4)
  );

  seg7_mux #(.BASE(32'h10), .DIGITS(5), .CNT_BITS(4), .BRIGHT_BITS(4)) u5 (
    .clk(clk), .reset(reset), .strobe(strobe), .rw(rw), .addr(addr), .data(data),
    .rdata(rdata5), .ack(ack5), .seg(seg5), .an(an5)
  );

  always #5 clk = ~clk;

  // Number of non-reset edges since the last reset edge.
  int cyc = 0;
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  int total = 0;
  int bad = 0;

  logic [15:0] hex_m   = '0;
  logic [3:0]  dp_m    = '0;
  logic [3:0]  blank_m = '0;
  logic [3:0]  duty_m  = 4'hF;
  logic [31:0] rd_m    = '0;
  int lowcnt;
  int an3low;

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        hit;
    logic [31:0] rd;
  } bus_vec_t;

  bus_vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return g[n];
  endfunction

  // Each call advances one clock per iteration, then checks the outputs.
  // Expected values come from the edge count since reset.
  task automatic check_cycles(input int n, input bit chk5);
    int c, ph, d4, d5;
    logic lit;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic [4:0] e_an5;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      c  = cyc - 1;
      ph = c % 16;
      d4 = (c / 16) % 4;
      lit = (duty_m == 4'hF) || (ph < int'(duty_m));
      e_an  = 4'hF;
      e_seg = 8'hFF;
      if (lit && !blank_m[d4]) begin
        e_an[d4] = 1'b0;
        e_seg = {~dp_m[d4], glyph(hex_m[d4*4 +: 4])};
      end
      chk("an4", 32'(an4), 32'(e_an));
      chk("seg4", 32'(seg4), 32'(e_seg));
      if (an4 != 4'hF) lowcnt++;
      if (an4[3] == 1'b0) an3low++;
      if (chk5) begin
        d5 = (c / 16) % 5;
        e_an5 = 5'h1F;
        e_an5[d5] = 1'b0;
        chk("an5", 32'(an5), 32'(e_an5));
        chk("seg5", 32'(seg5), 32'h0000_00C0);
      end
    end
  endtask

  task automatic bus_op(input bus_vec_t v);
    strobe = 1'b1;
    rw = v.rw;
    addr = v.addr;
    data = v.data;
    @(posedge clk);
    @(negedge clk);
    strobe = 1'b0;
    if (v.hit && v.rw) begin
      case (v.addr[1:0])
        2'd0: hex_m = v.data[15:0];
        2'd1: dp_m = v.data[3:0];
        2'd2: blank_m = v.data[3:0];
        default: duty_m = v.data[3:0];
      endcase
    end
    if (v.hit && !v.rw) rd_m = RD_EN ? v.rd : 32'h0;
    chk("bus_ack", 32'(ack4), 32'(v.hit));
    chk("bus_rdata", rdata4, rd_m);
    @(posedge clk);
    @(negedge clk);
    chk("ack_drop", 32'(ack4), 32'h0);
  endtask

  initial begin
    bus_vec_t v;
    bit found;

    vecs[0]  = '{1'b0, 32'h10, 32'h0,         1'b1, 32'h0};
    vecs[1]  = '{1'b0, 32'h13, 32'h0,         1'b1, 32'hF};
    vecs[2]  = '{1'b1, 32'h10, 32'hFFFF_A5C3, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h10, 32'h0,         1'b1, 32'h0000_A5C3};
    vecs[4]  = '{1'b1, 32'h11, 32'hFFFF_FFF2, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h11, 32'h0,         1'b1, 32'h2};
    vecs[6]  = '{1'b1, 32'h12, 32'h0000_0008, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h12, 32'h0,         1'b1, 32'h8};
    vecs[8]  = '{1'b1, 32'h14, 32'h0,         1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h20, 32'h0,         1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h10, 32'h0,         1'b1, 32'h0000_A5C3};
    vecs[11] = '{1'b1, 32'h13, 32'h0000_01F4, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 32'h13, 32'h0,         1'b1, 32'h4};

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_an4", 32'(an4), 32'hF);
    chk("rst_seg4", 32'(seg4), 32'hFF);
    chk("rst_an5", 32'(an5), 32'h1F);
    chk("rst_seg5", 32'(seg5), 32'hFF);
    chk("rst_ack", 32'(ack4), 32'h0);
    chk("rst_rdata", rdata4, 32'h0);
    reset = 1'b0;

    // Idle scan: both builds, through one 5-digit wrap
    lowcnt = 0;
    check_cycles(96, 1'b1);

    // Register table
    for (int i = 0; i < 13; i++) bus_op(vecs[i]);

    // HEX=A5C3, DP=0010, BLANK=1000, duty=4: digits 0..2 lit 4 of 16, digit 3 never
    lowcnt = 0;
    an3low = 0;
    check_cycles(64, 1'b0);
    chk("duty4_lowcnt", 32'(lowcnt), 32'd12);
    chk("blank3_never", 32'(an3low), 32'd0);

    v = '{1'b1, 32'h13, 32'h0, 1'b1, 32'h0};
    bus_op(v);
    lowcnt = 0;
    check_cycles(32, 1'b0);
    chk("duty0_lowcnt", 32'(lowcnt), 32'd0);

    v = '{1'b1, 32'h12, 32'h0, 1'b1, 32'h0};
    bus_op(v);
    v = '{1'b1, 32'h13, 32'hF, 1'b1, 32'h0};
    bus_op(v);
    lowcnt = 0;
    check_cycles(64, 1'b0);
    chk("dutyF_lowcnt", 32'(lowcnt), 32'd64);

    // Run into the middle of digit 2, then reset together with a read strobe
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      check_cycles(1, 1'b0);
      if (((cyc - 1) / 16) % 4 == 2 && (cyc - 1) % 16 == 5) found = 1'b1;
    end
    chk("find_digit2", 32'(found), 32'h1);
    reset = 1'b1;
    strobe = 1'b1;
    rw = 1'b0;
    addr = 32'h10;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ack", 32'(ack4), 32'h0);
    chk("mid_rst_an", 32'(an4), 32'hF);
    chk("mid_rst_seg", 32'(seg4), 32'hFF);
    chk("mid_rst_rdata", rdata4, 32'h0);
    strobe = 1'b0;
    reset = 1'b0;
    hex_m = '0;
    dp_m = '0;
    blank_m = '0;
    duty_m = 4'hF;
    rd_m = '0;
    check_cycles(20, 1'b0);
    v = '{1'b0, 32'h10, 32'h0, 1'b1, 32'h0};
    bus_op(v);
    v = '{1'b0, 32'h13, 32'h0, 1'b1, 32'hF};
    bus_op(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
